// File: rtl/led_fader_if.sv
// LED fader pattern/drive bundle: pattern and freeze in, dimmed LED drive out.
// Latency: n/a (wires only).
// Backpressure: none; pattern is sampled every clock and led_out is always valid.
interface led_fader_if;
  logic [15:0] pattern;
  logic        freeze;
  logic [15:0] led_out;

  // Upstream stage driving the pattern and observing the LEDs
  modport master (
    output pattern,
    output freeze,
    input  led_out
  );

  // The fader itself
  modport slave (
    input  pattern,
    input  freeze,
    output led_out
  );
endinterface

// File: rtl/led_fader.sv
// Comet-tail LED fader: per-LED 4-bit brightness, shared decay timer, 15-step PWM.
// Latency: pattern high at edge N loads brightness at N; led_out reflects it from N+1.
// Backpressure: none; freeze holds decay only. Optional gamma map: LED_FADER_GAMMA_EN.
module led_fader #(
  parameter logic [31:0] DECAY_DIV = 32'd250000
) (
  input  logic        clk,
  input  logic        rst,
  led_fader_if.slave  io
);

  logic [31:0] div_cnt_q, div_cnt_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic [3:0]  bright_q [16];
  logic [3:0]  bright_d [16];
  logic [3:0]  level    [16];
  logic [15:0] led_out_q, led_out_d;
  logic        decay_tick;

`ifdef LED_FADER_GAMMA_EN
  // Perceptual correction; endpoints stay 0 and 15 so off/on remain solid.
  function automatic logic [3:0] gamma_map(input logic [3:0] b);
    logic [3:0] g;
    case (b)
      4'd0, 4'd1, 4'd2:   g = 4'd0;
      4'd3, 4'd4, 4'd5:   g = 4'd1;
      4'd6, 4'd7:         g = 4'd2;
      4'd8:               g = 4'd3;
      4'd9:               g = 4'd4;
      4'd10:              g = 4'd5;
      4'd11:              g = 4'd6;
      4'd12:              g = 4'd8;
      4'd13:              g = 4'd10;
      4'd14:              g = 4'd12;
      default:            g = 4'd15;
    endcase
    return g;
  endfunction
`endif

  // Shared decay divider (frozen with freeze) and free-running PWM counter
  always_comb begin
    decay_tick = (div_cnt_q == (DECAY_DIV - 32'd1)) && !io.freeze;
    div_cnt_d  = div_cnt_q;
    if (!io.freeze) begin
      div_cnt_d = decay_tick ? 32'd0 : (div_cnt_q + 32'd1);
    end
    pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : (pwm_cnt_q + 4'd1);
  end

  // Per-LED brightness: a lit pattern bit reloads full scale and beats decay
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bright_d[i] = bright_q[i];
      if (io.pattern[i]) begin
        bright_d[i] = 4'd15;
      end else if (decay_tick && (bright_q[i] != 4'd0)) begin
        bright_d[i] = bright_q[i] - 4'd1;
      end
    end
  end

  // Brightness to PWM level, then compare against the shared PWM phase
  always_comb begin
    led_out_d = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef LED_FADER_GAMMA_EN
      level[i] = gamma_map(bright_q[i]);
`else
      level[i] = bright_q[i];
`endif
      led_out_d[i] = (level[i] > pwm_cnt_q);
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= '0;
      for (int i = 0; i < 16; i++) begin
        bright_q[i] <= '0;
      end
    end else begin
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
      for (int i = 0; i < 16; i++) begin
        bright_q[i] <= bright_d[i];
      end
    end
  end

  assign io.led_out = led_out_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with DECAY_DIV=4; expected values are hand-derived.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Works for both the linear and the LED_FADER_GAMMA_EN build.
module tb_led_fader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fader_if bus ();

  led_fader #(.DECAY_DIV(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges; returns 1 unit after the last reset edge with rst high,
  // so the next edge is the first sampling edge.
  task automatic reset_pulse();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Expected PWM level for a brightness value
  function automatic int lvl(input int b);
`ifdef LED_FADER_GAMMA_EN
    int tbl [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
    return tbl[b];
`else
    return b;
`endif
  endfunction

  // Staggered loads so that by edge 40 the LEDs sit at distinct levels
  function automatic logic [15:0] pat_for(input int e);
    logic [15:0] p;
    case (e)
      1:       p = 16'h0008;   // 10 ticks -> 5
      13:      p = 16'h0001;   // 7 ticks  -> 8
      17:      p = 16'h0004;   // 6 ticks  -> 9
      29:      p = 16'h0002;   // 3 ticks  -> 12
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  int hi [16];

  initial begin
    bus.pattern = 16'hFFFF;
    bus.freeze  = 1'b0;

    // Reset state: pattern and freeze ignored while held
    #2;
    rst = 1'b0;
    step();
    bus.freeze = 1'b1;
    step();
    check_eq("rst_led_out", {16'h0, bus.led_out}, 32'h0);
    check_eq("rst_bright0", {28'h0, dut.bright_q[0]}, 32'h0);
    check_eq("rst_div_cnt", dut.div_cnt_q, 32'h0);
    check_eq("rst_pwm_cnt", {28'h0, dut.pwm_cnt_q}, 32'h0);
    bus.freeze = 1'b0;
    rst = 1'b1;

    // Mid-run asynchronous reset
    for (int k = 0; k < 20; k++) step();
    check_eq("all_on_led_out", {16'h0, bus.led_out}, 32'hFFFF);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_led_out", {16'h0, bus.led_out}, 32'h0);
    check_eq("async_rst_bright5", {28'h0, dut.bright_q[5]}, 32'h0);
    check_eq("async_rst_div_cnt", dut.div_cnt_q, 32'h0);
    check_eq("async_rst_pwm_cnt", {28'h0, dut.pwm_cnt_q}, 32'h0);
    step();

    // Load and decay of LED 0
    bus.pattern = 16'h0000;
    reset_pulse();
    bus.pattern = 16'h0001;
    step();                                   // E1
    check_eq("load_bright0_e1", {28'h0, dut.bright_q[0]}, 32'd15);
    check_eq("load_led0_e1", {31'h0, bus.led_out[0]}, 32'd0);
    bus.pattern = 16'h0000;
    step();                                   // E2
    check_eq("load_led0_e2", {31'h0, bus.led_out[0]}, 32'd1);
    step();                                   // E3
    check_eq("decay_bright0_e3", {28'h0, dut.bright_q[0]}, 32'd15);
    step();                                   // E4: first tick
    check_eq("decay_bright0_e4", {28'h0, dut.bright_q[0]}, 32'd14);
    step();                                   // E5
    check_eq("decay_bright0_e5", {28'h0, dut.bright_q[0]}, 32'd14);
    for (int k = 0; k < 3; k++) step();       // E8
    check_eq("decay_bright0_e8", {28'h0, dut.bright_q[0]}, 32'd13);
    for (int k = 0; k < 52; k++) step();      // E60: fifteenth tick
    check_eq("decay_bright0_e60", {28'h0, dut.bright_q[0]}, 32'd0);
    for (int k = 0; k < 60; k++) step();      // many more ticks at 0
    check_eq("decay_no_wrap", {28'h0, dut.bright_q[0]}, 32'd0);
    check_eq("decay_led0_off", {31'h0, bus.led_out[0]}, 32'd0);

    // Load wins over a coincident decay tick
    reset_pulse();
    bus.pattern = 16'h0000;
    for (int k = 0; k < 3; k++) step();       // E3: counter at DECAY_DIV-1
    check_eq("coll_div_cnt_e3", dut.div_cnt_q, 32'd3);
    bus.pattern = 16'h0080;
    step();                                   // E4: tick and load together
    check_eq("coll_bright7", {28'h0, dut.bright_q[7]}, 32'd15);
    check_eq("coll_div_wrap", dut.div_cnt_q, 32'd0);
    bus.pattern = 16'h0000;

    // Freeze holds decay, PWM keeps running; duty cycles per level
    reset_pulse();
    for (int e = 1; e <= 40; e++) begin
      bus.pattern = pat_for(e);
      step();
    end
    bus.pattern = 16'h0010;                   // loads still apply under freeze
    bus.freeze  = 1'b1;
    check_eq("pre_frz_bright3", {28'h0, dut.bright_q[3]}, 32'd5);
    check_eq("pre_frz_bright2", {28'h0, dut.bright_q[2]}, 32'd9);
    for (int k = 0; k < 100; k++) step();     // E140
    check_eq("frz_bright0", {28'h0, dut.bright_q[0]}, 32'd8);
    check_eq("frz_bright1", {28'h0, dut.bright_q[1]}, 32'd12);
    check_eq("frz_bright2", {28'h0, dut.bright_q[2]}, 32'd9);
    check_eq("frz_bright3", {28'h0, dut.bright_q[3]}, 32'd5);
    check_eq("frz_bright4", {28'h0, dut.bright_q[4]}, 32'd15);
    check_eq("frz_div_cnt", dut.div_cnt_q, 32'd0);
    check_eq("frz_pwm_cnt", {28'h0, dut.pwm_cnt_q}, 32'd5);  // 140 mod 15

    for (int b = 0; b < 16; b++) hi[b] = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      for (int b = 0; b < 16; b++) hi[b] += int'(bus.led_out[b]);
    end
    check_eq("duty_b8",  hi[0], lvl(8));
    check_eq("duty_b12", hi[1], lvl(12));
    check_eq("duty_b9",  hi[2], lvl(9));
    check_eq("duty_b5",  hi[3], lvl(5));
    check_eq("duty_b15", hi[4], 32'd15);
    check_eq("duty_b0",  hi[5], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
